tl_sink_remapper: RTL and testbench

- TileLink sink-ID width converter for narrowing: device sink IDs (DeviceSinkWidth) are compacted into a small host sink space (HostSinkWidth).
- Grant/GrantData sink IDs on channel D are allocated into a tracking table. Channel E GrantAck is translated back to the original device sink, which frees the entry.
- A/B/C pass through unchanged. Sits between a coherent host (core/L1) and a device (LLC/crossbar) with a wider sink space.

---
 rtl/tl_sink_remapper_pkg.sv | 28 ++
 rtl/tl_sink_remapper_if.sv | 74 +++++++
 rtl/tl_sink_remapper_alloc.sv | 61 ++++++
 rtl/tl_sink_remapper.sv | 163 ++++++++++++++++
 tb/tb_tl_sink_remapper.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_sink_remapper_pkg.sv
// Shared TileLink definitions for the sink remapper: D-channel opcodes,
// the D-channel FSM state type and the beats-per-message helper.
package tl_sink_remapper_pkg;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1,
        D_HINT_ACK        = 3'd2,
        D_GRANT           = 3'd4,
        D_GRANT_DATA      = 3'd5,
        D_RELEASE_ACK     = 3'd6
    } tl_d_op_e;

    typedef enum logic {
        D_IDLE,
        D_BURST
    } d_state_e;

    // Number of bus beats in a D message: multi-beat only for data-carrying
    // opcodes whose transfer is wider than one bus word.
    function automatic int unsigned tl_d_beats(logic [2:0] opcode, int unsigned size,
                                               int unsigned bus_lg2);
        if ((opcode == D_ACCESS_ACK_DATA || opcode == D_GRANT_DATA) && size > bus_lg2)
            return 32'd1 << (size - bus_lg2);
        return 32'd1;
    endfunction

endpackage

// File: rtl/tl_sink_remapper_if.sv
// TileLink A/B/C/D/E bundle. The master modport is the side that issues
// requests (host role); the slave modport is the side that serves them.
interface tl_sink_remapper_if #(
    parameter int DataWidth   = 64,
    parameter int AddrWidth   = 56,
    parameter int SourceWidth = 1,
    parameter int SinkWidth   = 1,
    parameter int MaxSize     = 6
);
    localparam int SizeWidth = $clog2(MaxSize + 1);
    localparam int MaskWidth = DataWidth / 8;

    logic                   a_valid, a_ready, a_corrupt;
    logic [2:0]             a_opcode, a_param;
    logic [SizeWidth-1:0]   a_size;
    logic [SourceWidth-1:0] a_source;
    logic [AddrWidth-1:0]   a_address;
    logic [MaskWidth-1:0]   a_mask;
    logic [DataWidth-1:0]   a_data;

    logic                   b_valid, b_ready, b_corrupt;
    logic [2:0]             b_opcode;
    logic [1:0]             b_param;
    logic [SizeWidth-1:0]   b_size;
    logic [SourceWidth-1:0] b_source;
    logic [AddrWidth-1:0]   b_address;
    logic [MaskWidth-1:0]   b_mask;
    logic [DataWidth-1:0]   b_data;

    logic                   c_valid, c_ready, c_corrupt;
    logic [2:0]             c_opcode, c_param;
    logic [SizeWidth-1:0]   c_size;
    logic [SourceWidth-1:0] c_source;
    logic [AddrWidth-1:0]   c_address;
    logic [DataWidth-1:0]   c_data;

    logic                   d_valid, d_ready, d_denied, d_corrupt;
    logic [2:0]             d_opcode;
    logic [1:0]             d_param;
    logic [SizeWidth-1:0]   d_size;
    logic [SourceWidth-1:0] d_source;
    logic [SinkWidth-1:0]   d_sink;
    logic [DataWidth-1:0]   d_data;

    logic                   e_valid, e_ready;
    logic [SinkWidth-1:0]   e_sink;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
        output b_ready,
        output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
        input  c_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready,
        output e_valid, e_sink,
        input  e_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
        input  b_ready,
        input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
        output c_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready,
        input  e_valid, e_sink,
        output e_ready
    );

endinterface

// File: rtl/tl_sink_remapper_alloc.sv
// Sink allocation table: per-entry valid bit and original device sink,
// lowest-free priority encoder with full flag, an allocate port and a
// free port that shares its index with the combinational lookup.
module tl_sink_alloc_table #(
    parameter int NumEntries = 2,
    parameter int IdxWidth   = 1,
    parameter int SinkWidth  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic [IdxWidth-1:0]  free_idx_o,
    output logic                 full_o,
    input  logic                 alloc_i,
    input  logic [IdxWidth-1:0]  alloc_idx_i,
    input  logic [SinkWidth-1:0] alloc_sink_i,
    input  logic                 free_i,
    input  logic [IdxWidth-1:0]  lookup_idx_i,
    output logic [SinkWidth-1:0] lookup_sink_o,
    output logic                 lookup_valid_o
);
    logic [NumEntries-1:0] valid_q;
    logic [SinkWidth-1:0]  sink_q [NumEntries];

    // Lowest free entry wins; the downward scan leaves the smallest index last.
    always_comb begin
        free_idx_o = '0;
        full_o     = &valid_q;
        for (int i = NumEntries - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx_o = IdxWidth'(i);
        end
    end

    // Lookup by host sink; indices beyond the table match nothing and read zero.
    always_comb begin
        lookup_sink_o  = '0;
        lookup_valid_o = 1'b0;
        for (int i = 0; i < NumEntries; i++) begin
            if (lookup_idx_i == IdxWidth'(i)) begin
                lookup_sink_o  = sink_q[i];
                lookup_valid_o = valid_q[i];
            end
        end
    end

    // Entry update; a same-cycle free and allocate always target different entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < NumEntries; i++) sink_q[i] <= '0;
        end else begin
            for (int i = 0; i < NumEntries; i++) begin
                if (free_i && lookup_idx_i == IdxWidth'(i)) valid_q[i] <= 1'b0;
                if (alloc_i && alloc_idx_i == IdxWidth'(i)) begin
                    valid_q[i] <= 1'b1;
                    sink_q[i]  <= alloc_sink_i;
                end
            end
        end
    end

endmodule

// File: rtl/tl_sink_remapper.sv
// TileLink sink-ID narrowing converter. Grant/GrantData sinks from the
// device are compacted into a small host sink space; GrantAck on E is
// mapped back and frees the entry. A/B/C pass straight through.
// Optional: define TL_SINK_REMAPPER_ERR_EN to drop GrantAcks that name an
// unallocated entry and raise the sticky err_o flag.
module tl_sink_remapper #(
    parameter int DataWidth       = 64,
    parameter int AddrWidth       = 56,
    parameter int SourceWidth     = 1,
    parameter int HostSinkWidth   = 1,
    parameter int DeviceSinkWidth = 8,
    parameter int MaxSize         = 6,
    parameter int NumEntries      = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    tl_sink_remapper_if.slave  host,
    tl_sink_remapper_if.master device
`ifdef TL_SINK_REMAPPER_ERR_EN
    ,
    output logic               err_o
`endif
);
    import tl_sink_remapper_pkg::*;

    localparam int unsigned BusLg2 = $clog2(DataWidth / 8);
    localparam int BeatW = MaxSize + 1;
    localparam logic [BeatW-1:0] BeatOne = BeatW'(1);

    assign device.a_valid   = host.a_valid;
    assign device.a_opcode  = host.a_opcode;
    assign device.a_param   = host.a_param;
    assign device.a_size    = host.a_size;
    assign device.a_source  = host.a_source;
    assign device.a_address = host.a_address;
    assign device.a_mask    = host.a_mask;
    assign device.a_data    = host.a_data;
    assign device.a_corrupt = host.a_corrupt;
    assign host.a_ready     = device.a_ready;

    assign host.b_valid     = device.b_valid;
    assign host.b_opcode    = device.b_opcode;
    assign host.b_param     = device.b_param;
    assign host.b_size      = device.b_size;
    assign host.b_source    = device.b_source;
    assign host.b_address   = device.b_address;
    assign host.b_mask      = device.b_mask;
    assign host.b_data      = device.b_data;
    assign host.b_corrupt   = device.b_corrupt;
    assign device.b_ready   = host.b_ready;

    assign device.c_valid   = host.c_valid;
    assign device.c_opcode  = host.c_opcode;
    assign device.c_param   = host.c_param;
    assign device.c_size    = host.c_size;
    assign device.c_source  = host.c_source;
    assign device.c_address = host.c_address;
    assign device.c_data    = host.c_data;
    assign device.c_corrupt = host.c_corrupt;
    assign host.c_ready     = device.c_ready;

    assign host.d_opcode    = device.d_opcode;
    assign host.d_param     = device.d_param;
    assign host.d_size      = device.d_size;
    assign host.d_source    = device.d_source;
    assign host.d_denied    = device.d_denied;
    assign host.d_data      = device.d_data;
    assign host.d_corrupt   = device.d_corrupt;

    d_state_e                   state_q;
    logic [BeatW-1:0]           left_q;
    logic [HostSinkWidth-1:0]   idx_q;
    logic [HostSinkWidth-1:0]   free_idx;
    logic                       full;
    logic [DeviceSinkWidth-1:0] lookup_sink;
    logic                       lookup_valid;
    logic [BeatW-1:0]           d_beats;
    logic                       is_grant, d_stall, d_fire, alloc, e_free;

    assign d_beats  = BeatW'(tl_d_beats(device.d_opcode, 32'(device.d_size), BusLg2));
    assign is_grant = (device.d_opcode == D_GRANT) || (device.d_opcode == D_GRANT_DATA);
    // Only a first Grant beat needs a free entry; burst beats reuse the held one.
    assign d_stall  = (state_q == D_IDLE) && is_grant && full;
    assign d_fire   = device.d_valid && host.d_ready && !d_stall;
    assign alloc    = d_fire && (state_q == D_IDLE) && is_grant;

    // D handshake forwarding and host sink selection.
    always_comb begin
        host.d_valid   = device.d_valid && !d_stall;
        device.d_ready = host.d_ready && !d_stall;
        host.d_sink    = idx_q;
        if (state_q == D_IDLE) host.d_sink = is_grant ? free_idx : '0;
    end

    // D message FSM: remembers the host sink and beats left in a burst.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= D_IDLE;
            left_q  <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                D_IDLE: begin
                    if (d_fire && d_beats > BeatOne) begin
                        state_q <= D_BURST;
                        left_q  <= d_beats - BeatOne;
                        idx_q   <= is_grant ? free_idx : '0;
                    end
                end
                D_BURST: begin
                    if (d_fire) begin
                        left_q <= left_q - BeatOne;
                        if (left_q == BeatOne) state_q <= D_IDLE;
                    end
                end
                default: state_q <= D_IDLE;
            endcase
        end
    end

    assign device.e_sink = lookup_sink;

`ifdef TL_SINK_REMAPPER_ERR_EN
    logic err_q;
    logic e_bad;

    assign e_bad          = !lookup_valid;
    assign device.e_valid = host.e_valid && !e_bad;
    assign host.e_ready   = e_bad || device.e_ready;
    assign e_free         = host.e_valid && device.e_ready && !e_bad;
    assign err_o          = err_q;

    // Sticky flag for a GrantAck naming an entry that is not outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else if (host.e_valid && e_bad) err_q <= 1'b1;
    end
`else
    assign device.e_valid = host.e_valid;
    assign host.e_ready   = device.e_ready;
    // Freeing an entry that is already free changes nothing, so gate on valid.
    assign e_free         = host.e_valid && device.e_ready && lookup_valid;
`endif

    tl_sink_alloc_table #(
        .NumEntries (NumEntries),
        .IdxWidth   (HostSinkWidth),
        .SinkWidth  (DeviceSinkWidth)
    ) u_table (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .free_idx_o     (free_idx),
        .full_o         (full),
        .alloc_i        (alloc),
        .alloc_idx_i    (free_idx),
        .alloc_sink_i   (device.d_sink),
        .free_i         (e_free),
        .lookup_idx_i   (host.e_sink),
        .lookup_sink_o  (lookup_sink),
        .lookup_valid_o (lookup_valid)
    );

endmodule

// File: tb/tb_tl_sink_remapper.sv
// Testbench for tl_sink_remapper: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// table-level reference model.
module tb_tl_sink_remapper;
    localparam int DW = 64, AW = 56, SW = 1, HSW = 1, DSW = 8, MS = 6, NE = 2;

    logic clk = 1'b0;
    logic rst;
    logic err;
    always #5 clk = ~clk;

    tl_sink_remapper_if #(.DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW),
                          .SinkWidth(HSW), .MaxSize(MS)) host_bus ();
    tl_sink_remapper_if #(.DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW),
                          .SinkWidth(DSW), .MaxSize(MS)) dev_bus ();

    tl_sink_remapper #(
        .DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW), .HostSinkWidth(HSW),
        .DeviceSinkWidth(DSW), .MaxSize(MS), .NumEntries(NE)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .host   (host_bus),
        .device (dev_bus)
`ifdef TL_SINK_REMAPPER_ERR_EN
        ,
        .err_o  (err)
`endif
    );
`ifndef TL_SINK_REMAPPER_ERR_EN
    assign err = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: table contents, burst progress, sticky error.
    bit        mvalid [NE];
    logic [7:0] msink [NE];
    int        burst_left;
    int        burst_sink;
    int        hold_op, hold_size;
    bit        merr;
    // Per-cycle decisions taken at check time, applied at the clock edge.
    bit        c_dfire, c_efree, c_ebad, c_grant;
    int        c_low, c_op, c_size;
    logic [7:0] c_dsink;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int msg_beats(int op, int size);
        if ((op == 1 || op == 5) && size > 3) return 1 << (size - 3);
        return 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            mvalid[i] = 1'b0;
            msink[i]  = 8'h00;
        end
        burst_left = 0;
        burst_sink = 0;
        merr       = 1'b0;
    endtask

    // Compare every DUT output against what the model says it must be now.
    task automatic model_check();
        bit in_burst, full, stall, ev;
        int hs;
        logic [7:0] exp_esink;
        in_burst = burst_left > 0;
        c_op     = int'(dev_bus.d_opcode);
        c_size   = int'(dev_bus.d_size);
        c_dsink  = dev_bus.d_sink;
        c_grant  = (c_op == 4 || c_op == 5);
        c_low    = -1;
        for (int i = 0; i < NE; i++) if (!mvalid[i] && c_low < 0) c_low = i;
        full  = (c_low < 0);
        stall = !in_burst && c_grant && full;
        chk("d_valid", host_bus.d_valid, dev_bus.d_valid && !stall);
        chk("d_ready", dev_bus.d_ready, host_bus.d_ready && !stall);
        if (dev_bus.d_valid && !stall) begin
            chk("d_sink", host_bus.d_sink,
                in_burst ? burst_sink : (c_grant ? c_low : 0));
            chk("d_data", host_bus.d_data, dev_bus.d_data);
        end
        c_dfire = dev_bus.d_valid && host_bus.d_ready && !stall;

        ev = host_bus.e_valid;
        hs = int'(host_bus.e_sink);
        exp_esink = (hs < NE) ? msink[hs] : 8'h00;
`ifdef TL_SINK_REMAPPER_ERR_EN
        c_ebad = (hs >= NE) || !mvalid[hs];
`else
        c_ebad = 1'b0;
`endif
        chk("e_valid", dev_bus.e_valid, ev && !c_ebad);
        chk("e_ready", host_bus.e_ready, c_ebad || dev_bus.e_ready);
        if (ev && !c_ebad) chk("e_sink", dev_bus.e_sink, exp_esink);
        c_efree = ev && dev_bus.e_ready && !c_ebad;

        chk("a_pass", {dev_bus.a_valid, dev_bus.a_address},
            {host_bus.a_valid, host_bus.a_address});
        chk("a_ready", host_bus.a_ready, dev_bus.a_ready);
        chk("b_pass", {host_bus.b_valid, host_bus.b_address},
            {dev_bus.b_valid, dev_bus.b_address});
        chk("c_pass", {dev_bus.c_valid, dev_bus.c_data[62:0]},
            {host_bus.c_valid, host_bus.c_data[62:0]});
        chk("err_o", err, merr);
    endtask

    task automatic model_update();
        int nb;
        if (rst) begin
            model_reset();
            return;
        end
        if (host_bus.e_valid && c_ebad) merr = 1'b1;
        if (c_efree && int'(host_bus.e_sink) < NE) mvalid[int'(host_bus.e_sink)] = 1'b0;
        if (c_dfire) begin
            if (burst_left > 0) begin
                burst_left--;
            end else begin
                nb = msg_beats(c_op, c_size);
                if (c_grant) begin
                    mvalid[c_low] = 1'b1;
                    msink[c_low]  = c_dsink;
                end
                if (nb > 1) begin
                    burst_left = nb - 1;
                    burst_sink = c_grant ? c_low : 0;
                    hold_op    = c_op;
                    hold_size  = c_size;
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(bit v, int op, int size, logic [7:0] sink);
        dev_bus.d_valid  = v;
        dev_bus.d_opcode = 3'(op);
        dev_bus.d_size   = 3'(size);
        dev_bus.d_sink   = sink;
        dev_bus.d_data   = {$urandom, $urandom};
        host_bus.d_ready = 1'b1;
    endtask

    task automatic drive_e(bit v, int sink);
        host_bus.e_valid = v;
        host_bus.e_sink  = 1'(sink);
        dev_bus.e_ready  = 1'b1;
    endtask

    task automatic idle();
        drive_d(1'b0, 0, 0, 8'h00);
        drive_e(1'b0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
    endtask

    task automatic ack(int hsink, logic [7:0] exp_dev);
        drive_e(1'b1, hsink);
        settle();
        chk("ack_map", dev_bus.e_sink, exp_dev);
        advance();
        drive_e(1'b0, 0);
    endtask

    task automatic grant(int op, int size, logic [7:0] dsink, int exp_host);
        drive_d(1'b1, op, size, dsink);
        settle();
        chk("grant_sink", host_bus.d_sink, exp_host);
        advance();
        drive_d(1'b0, 0, 0, 8'h00);
    endtask

    task automatic randomize_abc();
        host_bus.a_valid   = 1'($urandom);
        host_bus.a_opcode  = 3'($urandom);
        host_bus.a_param   = 3'($urandom);
        host_bus.a_size    = 3'($urandom);
        host_bus.a_source  = 1'($urandom);
        host_bus.a_address = {$urandom, $urandom};
        host_bus.a_mask    = 8'($urandom);
        host_bus.a_data    = {$urandom, $urandom};
        host_bus.a_corrupt = 1'($urandom);
        dev_bus.a_ready    = 1'($urandom);
        dev_bus.b_valid    = 1'($urandom);
        dev_bus.b_opcode   = 3'($urandom);
        dev_bus.b_param    = 2'($urandom);
        dev_bus.b_size     = 3'($urandom);
        dev_bus.b_source   = 1'($urandom);
        dev_bus.b_address  = {$urandom, $urandom};
        dev_bus.b_mask     = 8'($urandom);
        dev_bus.b_data     = {$urandom, $urandom};
        dev_bus.b_corrupt  = 1'($urandom);
        host_bus.b_ready   = 1'($urandom);
        host_bus.c_valid   = 1'($urandom);
        host_bus.c_opcode  = 3'($urandom);
        host_bus.c_param   = 3'($urandom);
        host_bus.c_size    = 3'($urandom);
        host_bus.c_source  = 1'($urandom);
        host_bus.c_address = {$urandom, $urandom};
        host_bus.c_data    = {$urandom, $urandom};
        host_bus.c_corrupt = 1'($urandom);
        dev_bus.c_ready    = 1'($urandom);
    endtask

    initial begin
        int ops [5];
        int op, size;
        ops = '{0, 1, 4, 5, 6};
        randomize_abc();
        dev_bus.d_param   = 2'b00;
        dev_bus.d_source  = 1'b0;
        dev_bus.d_denied  = 1'b0;
        dev_bus.d_corrupt = 1'b0;
        idle();
        model_reset();
        hold_op = 0;
        hold_size = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: nothing presented, no error.
        settle();
        chk("rst_d_valid", host_bus.d_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        advance();

        // Single Grant and its GrantAck.
        grant(4, 3, 8'hA5, 0);
        ack(0, 8'hA5);

        // GrantData burst of 8 beats on host sink 0, then a Grant on sink 1.
        for (int b = 0; b < 8; b++) begin
            drive_d(1'b1, 5, 6, 8'h22);
            settle();
            chk("burst_sink", host_bus.d_sink, 0);
            chk("burst_ready", dev_bus.d_ready, 1'b1);
            advance();
        end
        grant(4, 6, 8'h11, 1);
        ack(0, 8'h22);
        ack(1, 8'h11);

        // Full table stalls the third Grant until a GrantAck frees entry 0.
        grant(4, 6, 8'h01, 0);
        grant(4, 6, 8'h02, 1);
        drive_d(1'b1, 4, 6, 8'h03);
        settle();
        chk("full_d_ready", dev_bus.d_ready, 1'b0);
        chk("full_d_valid", host_bus.d_valid, 1'b0);
        advance();
        drive_e(1'b1, 0);
        settle();
        chk("free_cycle_stall", dev_bus.d_ready, 1'b0);
        chk("free_cycle_map", dev_bus.e_sink, 8'h01);
        advance();
        drive_e(1'b0, 0);
        settle();
        chk("after_free_ready", dev_bus.d_ready, 1'b1);
        chk("after_free_sink", host_bus.d_sink, 0);
        advance();
        drive_d(1'b0, 0, 0, 8'h00);
        ack(0, 8'h03);
        ack(1, 8'h02);

        // Same-cycle free of entry 0 and allocation: Grant lands on entry 1.
        grant(4, 6, 8'h44, 0);
        drive_d(1'b1, 4, 6, 8'h55);
        drive_e(1'b1, 0);
        settle();
        chk("same_cycle_sink", host_bus.d_sink, 1);
        chk("same_cycle_map", dev_bus.e_sink, 8'h44);
        advance();
        idle();
        grant(4, 6, 8'h66, 0);
        ack(1, 8'h55);
        ack(0, 8'h66);

        // Non-Grant burst leaves the table untouched.
        for (int b = 0; b < 8; b++) begin
            drive_d(1'b1, 1, 6, 8'h7F);
            settle();
            chk("aad_sink", host_bus.d_sink, 0);
            advance();
        end
        grant(4, 6, 8'h33, 0);
        ack(0, 8'h33);

        // Reset mid-burst forgets the burst and the outstanding Grant.
        for (int b = 0; b < 3; b++) begin
            drive_d(1'b1, 5, 6, 8'h77);
            settle();
            advance();
        end
        do_reset();
        grant(4, 6, 8'h12, 0);
        grant(4, 6, 8'h13, 1);
        ack(0, 8'h12);
        ack(1, 8'h13);

`ifdef TL_SINK_REMAPPER_ERR_EN
        // GrantAck to an unallocated entry is dropped and flagged.
        do_reset();
        drive_e(1'b1, 1);
        settle();
        chk("err_drop_valid", dev_bus.e_valid, 1'b0);
        chk("err_drop_ready", host_bus.e_ready, 1'b1);
        advance();
        drive_e(1'b0, 0);
        settle();
        chk("err_set", err, 1'b1);
        advance();
        do_reset();
        settle();
        chk("err_cleared", err, 1'b0);
        advance();
`else
        // GrantAck to an unallocated entry after reset maps to zero.
        do_reset();
        drive_e(1'b1, 1);
        settle();
        chk("stale_map", dev_bus.e_sink, 8'h00);
        chk("stale_valid", dev_bus.e_valid, 1'b1);
        advance();
        drive_e(1'b0, 0);
`endif

        // Randomized traffic on all channels, model-checked every cycle.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            randomize_abc();
            if (burst_left > 0) begin
                op = hold_op;
                size = hold_size;
            end else begin
                op = ops[$urandom % 5];
                size = int'($urandom % 7);
            end
            dev_bus.d_valid  = 1'($urandom);
            dev_bus.d_opcode = 3'(op);
            dev_bus.d_size   = 3'(size);
            dev_bus.d_sink   = 8'($urandom);
            dev_bus.d_data   = {$urandom, $urandom};
            host_bus.d_ready = ($urandom % 4) != 0;
            host_bus.e_valid = ($urandom % 3) == 0;
            host_bus.e_sink  = 1'($urandom);
            dev_bus.e_ready  = ($urandom % 4) != 0;
            rst              = ($urandom % 500) == 0;
            settle();
            advance();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
